// File: rtl/note_sequencer.sv
// Plays three latched lane note maps at a fixed tempo, exports look-ahead windows and judges
// key presses. Define WRONG_PRESS_PENALTY_EN to also count wrong presses as misses.
module note_sequencer #(
  parameter int unsigned TICKS_PER_STEP = 12500000,
  parameter int unsigned SONG_LEN       = 100,
  parameter int unsigned LOOKAHEAD      = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 pause,
  input  logic [SONG_LEN-1:0]  red_map,
  input  logic [SONG_LEN-1:0]  blue_map,
  input  logic [SONG_LEN-1:0]  yellow_map,
  input  logic [7:0]           total_notes,
  input  logic                 key_red,
  input  logic                 key_blue,
  input  logic                 key_yellow,
  output logic [6:0]           step_index,
  output logic [LOOKAHEAD-1:0] win_red,
  output logic [LOOKAHEAD-1:0] win_blue,
  output logic [LOOKAHEAD-1:0] win_yellow,
  output logic [7:0]           hit_count,
  output logic [7:0]           miss_count,
  output logic [7:0]           combo,
  output logic [7:0]           max_combo,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 playing,
  output logic                 done
);
  localparam int unsigned      TickW    = $clog2(TICKS_PER_STEP);
  localparam logic [TickW-1:0] LastTick = TickW'(TICKS_PER_STEP - 1);
  localparam logic [6:0]       LastStep = 7'(SONG_LEN - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StPlay, StPaused, StDone} state_e;
  state_e state_q, state_d;

  logic                start_q1, start_q2, start_edge;
  logic [2:0]          key_q1, key_q2, key_edge;
  logic [SONG_LEN-1:0] red_q, blue_q, yellow_q;
  logic [7:0]          total_q;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [6:0]          step_q, step_d;
  logic [2:0]          pend_q, pend_d, hits, wrong, missed;
  logic [7:0]          hit_q, hit_d, miss_q, miss_d, combo_q, combo_d, max_q, max_d;
  logic                hit_pulse_q, hit_pulse_d, miss_pulse_q, miss_pulse_d;
  logic [7:0]          note_miss;
  logic [8:0]          judged;

`ifdef WRONG_PRESS_PENALTY_EN
  // Penalty misses are excluded from the early-finish sum, so real misses are tracked apart.
  logic [7:0] note_miss_q, note_miss_d;
  assign note_miss = note_miss_q;
`else
  assign note_miss = miss_q;
`endif

  function automatic logic [1:0] count3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction

  assign start_edge = start_q1 & ~start_q2;
  assign key_edge   = key_q1 & ~key_q2;
  assign judged     = {1'b0, hit_q} + {1'b0, note_miss};

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    step_d       = step_q;
    pend_d       = pend_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    combo_d      = combo_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    hits         = '0;
    wrong        = '0;
    missed       = '0;
`ifdef WRONG_PRESS_PENALTY_EN
    note_miss_d  = note_miss_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) state_d = StLoad;
      end
      StLoad: begin
        tick_d  = '0;
        step_d  = '0;
        hit_d   = '0;
        miss_d  = '0;
        combo_d = '0;
        pend_d  = {yellow_map[0], blue_map[0], red_map[0]};
`ifdef WRONG_PRESS_PENALTY_EN
        note_miss_d = '0;
`endif
        state_d = (total_notes == 8'd0) ? StDone : StPlay;
      end
      StPlay: begin
        hits        = key_edge & pend_q;
        wrong       = key_edge & ~pend_q;
        pend_d      = pend_q & ~hits;
        hit_d       = sat_add(hit_q, count3(hits));
        combo_d     = (|wrong) ? 8'd0 : sat_add(combo_q, count3(hits));
        hit_pulse_d = |hits;
`ifdef WRONG_PRESS_PENALTY_EN
        if (|wrong) begin
          miss_d       = sat_add(miss_q, 2'd1);
          miss_pulse_d = 1'b1;
        end
`endif
        if (tick_q == LastTick) begin
          // Presses in this cycle were judged above, so only unhit notes count as misses.
          missed = pend_d;
          miss_d = sat_add(miss_d, count3(missed));
`ifdef WRONG_PRESS_PENALTY_EN
          note_miss_d = sat_add(note_miss_q, count3(missed));
`endif
          if (|missed) begin
            miss_pulse_d = 1'b1;
            combo_d      = '0;
          end
          tick_d = '0;
          if (step_q == LastStep) begin
            state_d = StDone;
          end else begin
            step_d = step_q + 7'd1;
            pend_d = {yellow_q[step_d], blue_q[step_d], red_q[step_d]};
          end
        end else begin
          tick_d = tick_q + TickW'(1);
        end
        if (state_d != StDone) begin
          if (judged >= {1'b0, total_q}) state_d = StDone;
          else if (pause)                state_d = StPaused;
        end
      end
      StPaused: begin
        if (!pause) state_d = StPlay;
      end
      default: state_d = StIdle;
    endcase
    max_d = (state_q == StLoad) ? 8'd0 : ((combo_d > max_q) ? combo_d : max_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      start_q1     <= 1'b0;
      start_q2     <= 1'b0;
      key_q1       <= '0;
      key_q2       <= '0;
      red_q        <= '0;
      blue_q       <= '0;
      yellow_q     <= '0;
      total_q      <= '0;
      tick_q       <= '0;
      step_q       <= '0;
      pend_q       <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      combo_q      <= '0;
      max_q        <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
`ifdef WRONG_PRESS_PENALTY_EN
      note_miss_q  <= '0;
`endif
    end else begin
      start_q1     <= start;
      start_q2     <= start_q1;
      key_q1       <= {key_yellow, key_blue, key_red};
      key_q2       <= key_q1;
      if (state_q == StLoad) begin
        red_q    <= red_map;
        blue_q   <= blue_map;
        yellow_q <= yellow_map;
        total_q  <= total_notes;
      end
      tick_q       <= tick_d;
      step_q       <= step_d;
      pend_q       <= pend_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      combo_q      <= combo_d;
      max_q        <= max_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
`ifdef WRONG_PRESS_PENALTY_EN
      note_miss_q  <= note_miss_d;
`endif
    end
  end

  assign playing    = (state_q == StPlay) || (state_q == StPaused);
  assign done       = (state_q == StDone);
  assign step_index = step_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign combo      = combo_q;
  assign max_combo  = max_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;

  // Shifting zero-fills past the last step, so window bits beyond the song read 0.
  assign win_red    = playing ? LOOKAHEAD'(red_q >> step_q) : '0;
  assign win_blue   = playing ? LOOKAHEAD'(blue_q >> step_q) : '0;
  assign win_yellow = playing ? LOOKAHEAD'(yellow_q >> step_q) : '0;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed scoreboard bench for note_sequencer with a 4-cycle step; honours
// WRONG_PRESS_PENALTY_EN when computing wrong-press expectations.
module tb_note_sequencer;
`ifdef WRONG_PRESS_PENALTY_EN
  localparam int Pen = 1;
`else
  localparam int Pen = 0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [99:0] red_map = '0, blue_map = '0, yellow_map = '0;
  logic [7:0]  total_notes = '0;
  logic        key_red = 1'b0, key_blue = 1'b0, key_yellow = 1'b0;
  logic [6:0]  step_index;
  logic [7:0]  win_red, win_blue, win_yellow;
  logic [7:0]  hit_count, miss_count, combo, max_combo;
  logic        hit_pulse, miss_pulse, playing, done;

  note_sequencer #(.TICKS_PER_STEP(4), .SONG_LEN(100), .LOOKAHEAD(8)) dut (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause),
    .red_map(red_map), .blue_map(blue_map), .yellow_map(yellow_map),
    .total_notes(total_notes), .key_red(key_red), .key_blue(key_blue),
    .key_yellow(key_yellow), .step_index(step_index), .win_red(win_red),
    .win_blue(win_blue), .win_yellow(win_yellow), .hit_count(hit_count),
    .miss_count(miss_count), .combo(combo), .max_combo(max_combo),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .playing(playing), .done(done)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: observed %0h with no expected value", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic timeout(input string what);
    n_vec++;
    n_err++;
    $display("FAIL timeout_%s: step_index=%0d playing=%0b done=%0b", what, step_index,
             playing, done);
  endtask

  task automatic wait_play();
    int n = 0;
    while (playing !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    if (playing !== 1'b1) timeout("play");
  endtask

  task automatic wait_step(input logic [6:0] s);
    int n = 0;
    while (step_index !== s && n < 1000) begin @(negedge clock); n++; end
    if (step_index !== s) timeout("step");
  endtask

  task automatic start_song();
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    start = 1'b1;
    wait_play();
  endtask

  task automatic press(input logic [2:0] m);
    {key_yellow, key_blue, key_red} = m;
    @(negedge clock);
    {key_yellow, key_blue, key_red} = 3'b000;
    @(negedge clock);
  endtask

  initial begin
    logic [99:0] m;
    int          cnt;

    // Reset state
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    expect_val("rst_step", 0); expect_val("rst_hit", 0); expect_val("rst_miss", 0);
    expect_val("rst_combo", 0); expect_val("rst_max", 0); expect_val("rst_flags", 0);
    expect_val("rst_win", 0);
    check(32'(step_index)); check(32'(hit_count)); check(32'(miss_count));
    check(32'(combo)); check(32'(max_combo));
    check({28'd0, hit_pulse, miss_pulse, playing, done});
    check({8'd0, win_red, win_blue, win_yellow});

    // Song 1: basic play and early finish
    red_map = 100'b1011; blue_map = '0; yellow_map = '0; total_notes = 8'd3;
    start_song();
    expect_val("s1_win_red", 32'h0b); expect_val("s1_step0", 0);
    check(32'(win_red)); check(32'(step_index));
    expect_val("s1_hit0", 1); expect_val("s1_combo0", 1); expect_val("s1_hit_pulse", 1);
    press(3'b001);
    check(32'(hit_count)); check(32'(combo)); check(32'(hit_pulse));
    expect_val("s1_pulse_once", 0);
    @(negedge clock);
    check(32'(hit_pulse));
    wait_step(7'd1);
    expect_val("s1_hit1", 2); expect_val("s1_combo1", 2); expect_val("s1_max1", 2);
    press(3'b001);
    check(32'(hit_count)); check(32'(combo)); check(32'(max_combo));
    wait_step(7'd3);
    expect_val("s1_miss", 1); expect_val("s1_combo_miss", 0); expect_val("s1_max", 2);
    expect_val("s1_step_after", 4);
    cnt = 0;
    while (miss_pulse !== 1'b1 && cnt < 20) begin @(negedge clock); cnt++; end
    if (miss_pulse !== 1'b1) timeout("miss_pulse");
    check(32'(miss_count)); check(32'(combo)); check(32'(max_combo)); check(32'(step_index));
    expect_val("s1_done_flags", 1); expect_val("s1_done_hit", 2); expect_val("s1_done_win", 0);
    @(negedge clock);
    check({30'd0, playing, done}); check(32'(hit_count)); check(32'(win_red));

    // Song 2: simultaneous hits, wrong press, pause
    red_map = 100'b1111; blue_map = '0; yellow_map = 100'b1; total_notes = 8'd5;
    start_song();
    expect_val("s2_sim_hit", 2); expect_val("s2_sim_combo", 2); expect_val("s2_sim_pulse", 1);
    press(3'b101);
    check(32'(hit_count)); check(32'(combo)); check(32'(hit_pulse));
    expect_val("s2_sim_pulse_once", 0); expect_val("s2_sim_hit_hold", 2);
    @(negedge clock);
    check(32'(hit_pulse)); check(32'(hit_count));
    wait_step(7'd1);
    expect_val("s2_combo3", 3); expect_val("s2_max3", 3);
    press(3'b001);
    check(32'(combo)); check(32'(max_combo));
    wait_step(7'd2);
    expect_val("s2_wrong_combo", 0); expect_val("s2_wrong_miss", Pen);
    expect_val("s2_wrong_hit", 3); expect_val("s2_wrong_max", 3);
    press(3'b010);
    check(32'(combo)); check(32'(miss_count)); check(32'(hit_count)); check(32'(max_combo));
    wait_step(7'd3);
    @(negedge clock);
    pause = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 5) key_red = 1'b1;
      if (i == 7) key_red = 1'b0;
    end
    expect_val("s2_pause_step", 3); expect_val("s2_pause_hit", 3); expect_val("s2_pause_play", 1);
    check(32'(step_index)); check(32'(hit_count)); check(32'(playing));
    pause = 1'b0;
    expect_val("s2_resume_cycles", 3); expect_val("s2_miss_total", 2 + Pen);
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (step_index !== 7'd4 && cnt < 100);
    check(32'(cnt)); check(32'(miss_count));
    expect_val("s2_early_done", 1);
    @(negedge clock);
    check(32'(done));

    // Song 3: end-of-song windows, start ignored mid-play, last-step finish
    m = '0;
    m[99:95] = '1;
    red_map = m; blue_map = m; yellow_map = m; total_notes = 8'd200;
    start_song();
    wait_step(7'd50);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    expect_val("s3_start_ign_step", 50); expect_val("s3_start_ign_play", 1);
    check(32'(step_index)); check(32'(playing));
    wait_step(7'd97);
    expect_val("s3_win97", {8'd0, 8'h07, 8'h07, 8'h07}); expect_val("s3_miss97", 6);
    check({8'd0, win_red, win_blue, win_yellow}); check(32'(miss_count));
    cnt = 0;
    while (done !== 1'b1 && cnt < 50) begin @(negedge clock); cnt++; end
    if (done !== 1'b1) timeout("last_step");
    expect_val("s3_end_step", 99); expect_val("s3_end_miss", 15); expect_val("s3_end_win", 0);
    check(32'(step_index)); check(32'(miss_count));
    check({8'd0, win_red, win_blue, win_yellow});

    // Song 4: zero notes finishes straight from LOAD
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total_notes = 8'd0;
    start = 1'b1;
    expect_val("s4_still_done", 1); expect_val("s4_load", 0); expect_val("s4_done", 1);
    expect_val("s4_step", 0); expect_val("s4_miss", 0);
    @(negedge clock);
    check({30'd0, playing, done});
    @(negedge clock);
    check({30'd0, playing, done});
    @(negedge clock);
    check({30'd0, playing, done}); check(32'(step_index)); check(32'(miss_count));

    // Song 5: asynchronous reset mid-play
    red_map = 100'b1111; blue_map = '0; yellow_map = '0; total_notes = 8'd10;
    start_song();
    expect_val("s5_hit", 1);
    press(3'b001);
    check(32'(hit_count));
    wait_step(7'd1);
    #2 resetn = 1'b0;
    #1;
    expect_val("s5_rst_hit", 0); expect_val("s5_rst_step", 0); expect_val("s5_rst_flags", 0);
    expect_val("s5_rst_win", 0); expect_val("s5_rst_max", 0);
    check(32'(hit_count)); check(32'(step_index));
    check({28'd0, hit_pulse, miss_pulse, playing, done});
    check({8'd0, win_red, win_blue, win_yellow}); check(32'(max_combo));
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Consumes the three 100-bit lane note maps (red, blue, yellow) and the total note count produced by the song-selection stage.
- Plays the selected song step by step at a fixed tempo.
- Presents a look-ahead window of upcoming notes per lane to the display stage.
- Judges player key presses against the current step and keeps hit, miss and combo counters for the score/display logic.

Parameters:
TICKS_PER_STEP, 12500000, clock cycles per song step (4 steps/s at 50 MHz); must be >= 2
SONG_LEN, 100, number of steps; equals map width
LOOKAHEAD, 8, number of upcoming steps exported per lane window

Ports:
clock  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  level; a rising edge begins a song from IDLE or DONE
pause  input  1  level; high holds playback in PAUSED
red_map  input  100  red lane notes; bit i = note at step i
blue_map  input  100  blue lane notes
yellow_map  input  100  yellow lane notes
total_notes  input  8  number of notes in the song
key_red  input  1  debounced level, synchronous to clock
key_blue  input  1  debounced level
key_yellow  input  1  debounced level
step_index  output  7  current step, 0..SONG_LEN-1
win_red  output  LOOKAHEAD  win_red[k] = latched red bit (step_index+k); 0 beyond SONG_LEN-1
win_blue  output  LOOKAHEAD  same for blue
win_yellow  output  LOOKAHEAD  same for yellow
hit_count  output  8  notes hit, saturating at 255
miss_count  output  8  notes missed, saturating at 255
combo  output  8  current consecutive hits, saturating at 255
max_combo  output  8  best combo this song
hit_pulse  output  1  one-cycle pulse on any hit
miss_pulse  output  1  one-cycle pulse on any miss
playing  output  1  high in PLAY or PAUSED
done  output  1  high in DONE

Behaviour:
- Reset is asynchronous, active-low. All outputs reset to 0, FSM to IDLE, latched maps to 0, key edge registers to 0.
- Start edge: start is registered and edge-detected; a rising edge is acted on one cycle later.
- FSM states: IDLE, LOAD, PLAY, PAUSED, DONE.
- IDLE / DONE -> LOAD on a start rising edge.
  - LOAD lasts exactly 1 cycle.
  - In LOAD: latch the three maps and total_notes; clear the counters, step_index and tick counter.
  - Map inputs are ignored outside LOAD.
- LOAD -> PLAY.
  - If the latched total_notes = 0, go LOAD -> DONE instead.
- PLAY <-> PAUSED: pause high moves PLAY -> PAUSED next cycle.
  - While paused, the tick counter freezes and key presses are ignored.
  - pause low returns to PLAY with the tick count preserved.
- Pending register per lane: loaded with the lane's latched bit at step_index on entry to each step (including step 0).
- Key judgement (PLAY only): each key is edge-detected on a registered 0->1 transition.
  - Edge on a lane with pending=1 is a hit: clear pending, hit_count += 1, combo += 1, hit_pulse=1.
  - Simultaneous hits on several lanes in the same cycle add the number of lanes hit to hit_count and combo.
- Wrong press: edge on a lane with pending=0 resets combo to 0 and changes no counter. See the optional feature for the penalty variant.
- Step boundary: occurs when the tick counter reaches TICKS_PER_STEP-1.
  - Each still-pending lane adds 1 to miss_count; miss_pulse=1 and combo=0 if any lane missed.
  - A key edge in the boundary cycle is judged before the miss evaluation.
- Then, unless it is the last step, step_index increments and the pending registers reload.
- max_combo updates every cycle to max(max_combo, next combo).
- Saturation: all counters saturate at 255, never wrap.
- PLAY -> DONE at the boundary of step SONG_LEN-1, or on the cycle after hit_count+miss_count (9-bit sum) >= latched total_notes.
- In DONE: counters and step_index hold, windows read 0.
- Start mid-PLAY or mid-PAUSED is ignored.
- Reset mid-song returns to IDLE immediately.

Optional Feature:
- Macro: WRONG_PRESS_PENALTY_EN.
- When defined: a wrong press also increments miss_count by 1 (saturating), pulses miss_pulse and resets combo. It does not contribute to the early-DONE sum.
- When undefined: wrong presses only reset combo.

Test Plan:
- Reset release, no start -> all outputs 0, state IDLE, windows 0.
- Basic play with TICKS_PER_STEP=4: red_map=100'b1011, others 0, total_notes=3, start edge, press key_red in steps 0 and 1 -> hit_count=2, combo=2, miss_count=1 at the step-3 boundary.
  - Early DONE follows on the next cycle (hits+misses=3=total_notes).
  - Expect max_combo=2, combo=0.
- Simultaneous hits: red and yellow bit 0 set; press both keys in the same cycle -> hit_count 0->2 in one cycle, single hit_pulse.
- Pause: pause asserted for 20 cycles mid-step -> step_index unchanged, presses ignored; on release the step completes after the remaining ticks only.
- Wrong press: no note in blue at step 2, press key_blue with combo=3 -> combo=0, miss_count unchanged.
  - With WRONG_PRESS_PENALTY_EN defined, miss_count also +1.
- Boundaries: total_notes=0 -> DONE two cycles after the start edge. Windows near the end: at step_index=97 with all maps=1, win bits [2:0]=1 and [7:3]=0. Reset asserted mid-PLAY -> outputs 0 asynchronously.
